// File: rtl/csa_acc_pkg.sv
// Shared constants and state encoding for the carry-save accumulator.
package csa_acc_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCUM   = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int unsigned COUNT_WIDTH = 8;
  localparam int unsigned SLICE       = 4;

  typedef enum logic [1:0] {
    StIdle    = IDLE,
    StAccum   = ACCUM,
    StResolve = RESOLVE,
    StDone    = DONE
  } state_e;

endpackage

// File: rtl/carry_lookahead_adder_4.sv
// 4-bit carry-lookahead adder with carry in and carry out.
module carry_lookahead_adder_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       co_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s_o  = p ^ c[3:0];
    co_o = c[4];
  end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder; one instance per bit forms the 3:2 carry-save row.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  always_comb begin
    s_o  = a_i ^ b_i ^ c_i;
    co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
  end

endmodule

// File: rtl/csa_accumulator.sv
// Streaming accumulator: carry-save absorption per operand, then a nibble-serial
// carry-lookahead resolve of the redundant (sum, carry) pair.
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ACC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_sum,
  output logic                   out_overflow,
  output logic [COUNT_WIDTH-1:0] out_count
);

  localparam int unsigned NumSlices = ACC_WIDTH / SLICE;
  localparam int unsigned IdxW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   s_q, s_d;
  logic [ACC_WIDTH-1:0]   c_q, c_d;
  logic [ACC_WIDTH-1:0]   r_q, r_d;
  logic                   cy_q, cy_d;
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [IdxW-1:0]        slice_q, slice_d;

  logic [ACC_WIDTH-1:0] op_ext;
  logic [ACC_WIDTH-1:0] c_shift;
  logic [ACC_WIDTH-1:0] fa_s;
  logic [ACC_WIDTH-1:0] fa_c;
  logic [SLICE-1:0]     s_nib;
  logic [SLICE-1:0]     c_nib;
  logic [SLICE-1:0]     cla_s;
  logic                 cla_co;

  assign op_ext  = ACC_WIDTH'(in_data);
  // Carries carry weight 2; the top carry bit leaves the word on the shift.
  assign c_shift = {c_q[ACC_WIDTH-2:0], 1'b0};

  for (genvar i = 0; i < ACC_WIDTH; i++) begin : g_csa
    full_adder u_fa (
      .a_i  (s_q[i]),
      .b_i  (c_shift[i]),
      .c_i  (op_ext[i]),
      .s_o  (fa_s[i]),
      .co_o (fa_c[i])
    );
  end

  assign s_nib = s_q[slice_q*SLICE +: SLICE];
  assign c_nib = c_shift[slice_q*SLICE +: SLICE];

  carry_lookahead_adder_4 u_cla (
    .a_i  (s_nib),
    .b_i  (c_nib),
    .c_i  (cy_q),
    .s_o  (cla_s),
    .co_o (cla_co)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    r_d     = r_q;
    cy_d    = cy_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    slice_d = slice_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          s_d     = op_ext;
          c_d     = '0;
          count_d = COUNT_WIDTH'(1);
          ovf_d   = 1'b0;
          cy_d    = 1'b0;
          slice_d = '0;
          state_d = in_last ? StResolve : StAccum;
        end
      end
      StAccum: begin
        if (in_valid) begin
          s_d = fa_s;
          c_d = fa_c;
          if (c_q[ACC_WIDTH-1]) ovf_d = 1'b1;
          if (count_q != '1) count_d = count_q + 1'b1;
          if (in_last) begin
            cy_d    = 1'b0;
            slice_d = '0;
            state_d = StResolve;
          end
        end
      end
      StResolve: begin
        r_d[slice_q*SLICE +: SLICE] = cla_s;
        cy_d = cla_co;
        if (slice_q == IdxW'(NumSlices - 1)) begin
          ovf_d   = ovf_q | cla_co;
          state_d = StDone;
        end else begin
          slice_d = slice_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      slice_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      r_q     <= r_d;
      cy_q    <= cy_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      slice_q <= slice_d;
    end
  end

  always_comb begin
    in_ready     = (state_q == StIdle) || (state_q == StAccum);
    out_valid    = (state_q == StDone);
    out_sum      = out_valid ? r_q : '0;
    out_overflow = out_valid ? ovf_q : 1'b0;
    out_count    = out_valid ? count_q : '0;
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator with WIDTH=4, ACC_WIDTH=8.
module tb_csa_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_overflow;
  logic [7:0] out_count;

  int errors = 0;
  int checks = 0;

  csa_accumulator #(
    .WIDTH     (4),
    .ACC_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operand for a single clock; inputs change 1 ns after the edge.
  task automatic send(input logic [3:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Called right after the last accept; measures latency and checks the result.
  task automatic wait_result(input string tag, input logic [7:0] sum, input logic ovf,
                             input logic [7:0] cnt);
    int n = 0;
    chk({tag, "_rdy_resolve"}, in_ready, 0);
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, 2);
    chk({tag, "_sum"}, out_sum, sum);
    chk({tag, "_ovf"}, out_overflow, ovf);
    chk({tag, "_count"}, out_count, cnt);
    chk({tag, "_rdy_done"}, in_ready, 0);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_rdy_after"}, in_ready, 1);
    chk({tag, "_valid_after"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_ovf", out_overflow, 0);
    chk("rst_count", out_count, 0);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1+1+1 = 3
    send(4'd1, 1'b0);
    send(4'd1, 1'b0);
    send(4'd1, 1'b1);
    wait_result("small", 8'h03, 1'b0, 8'd3);
    take("small");

    // 15*3 = 45
    send(4'd15, 1'b0);
    send(4'd15, 1'b0);
    send(4'd15, 1'b1);
    wait_result("max", 8'h2D, 1'b0, 8'd3);
    take("max");

    // 15*18 = 270 -> 14 with overflow
    for (int i = 0; i < 18; i++) send(4'd15, i == 17);
    wait_result("ovf", 8'h0E, 1'b1, 8'd18);
    take("ovf");

    send(4'd9, 1'b1);
    wait_result("single", 8'h09, 1'b0, 8'd1);
    take("single");

    // 7+8 = 15, then hold the result against backpressure and stray input.
    send(4'd7, 1'b0);
    send(4'd8, 1'b1);
    wait_result("bp", 8'h0F, 1'b0, 8'd2);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 4'd3;
      in_last  = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", out_sum, 8'h0F);
      chk("bp_hold_count", out_count, 8'd2);
      chk("bp_hold_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    take("bp");

    // 1+2+3 = 6 with gaps between operands
    send(4'd1, 1'b0);
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
    send(4'd2, 1'b0);
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
    send(4'd3, 1'b1);
    wait_result("gap", 8'h06, 1'b0, 8'd3);
    take("gap");

    // Reset while resolving, then 2+3 = 5
    send(4'd15, 1'b0);
    send(4'd15, 1'b1);
    chk("mid_in_resolve", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", out_sum, 0);
    chk("mid_rst_count", out_count, 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'd2, 1'b0);
    send(4'd3, 1'b1);
    wait_result("post_rst", 8'h05, 1'b0, 8'd2);
    take("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
